// File: rtl/digitalclock_setctrl.sv
// digitalclock_setctrl: mode/increment button controller that walks the settable clock fields and emits auto-repeating increment strobes.
// Define SETCTRL_TIMEOUT_EN to return to run after TIMEOUT_CYC idle cycles in a set state.
module digitalclock_setctrl #(
    parameter int N_FIELDS    = 2,
    parameter int REPEAT_DLY  = 8,
    parameter int REPEAT_PER  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic                inc,
    output logic [N_FIELDS-1:0] set_sel,
    output logic                setting,
    output logic                inc_pulse
);
    localparam int IW   = N_FIELDS > 1 ? $clog2(N_FIELDS) : 1;
    localparam int RMAX = REPEAT_PER > REPEAT_DLY ? REPEAT_PER : REPEAT_DLY;
    localparam int CW   = $clog2(RMAX + 1);
    localparam logic [IW-1:0] LAST = IW'(N_FIELDS - 1);
    localparam logic [CW-1:0] DLY  = CW'(REPEAT_DLY);
    localparam logic [CW-1:0] PER  = CW'(REPEAT_PER);

    if (N_FIELDS < 1 || N_FIELDS > 8 || REPEAT_DLY < 2 || REPEAT_PER < 1 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("digitalclock_setctrl: parameter out of legal range");
    end

    logic          mode_q, inc_q, in_set, rep;
    logic [IW-1:0] idx;
    logic [CW-1:0] rcnt;
    logic          mode_rise, inc_rise, due, tmo, in_set_d, pulse_d, rep_d;
    logic [IW-1:0] idx_d;
    logic [CW-1:0] rcnt_d;

    assign mode_rise = mode & ~mode_q;
    assign inc_rise  = inc & ~inc_q;
    assign due       = rcnt == (rep ? PER : DLY);

`ifdef SETCTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 2);
    logic [TW-1:0] tcnt;
    logic          idle;
    assign idle = in_set & ~inc & ~mode_rise;
    // tcnt holds idle cycles before the current one, so the expiring edge is the (TIMEOUT_CYC-1)th idle sample
    assign tmo  = idle & (tcnt == TLIM);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tcnt <= '0;
        else      tcnt <= idle ? tcnt + 1'b1 : '0;
    end
`else
    assign tmo = 1'b0;
`endif

    assign in_set_d = mode_rise ? (~in_set | (idx != LAST)) : (in_set & ~tmo);
    assign idx_d    = mode_rise ? ((in_set && idx != LAST) ? idx + 1'b1 : '0) : (tmo ? '0 : idx);

    // rcnt==0 means no repeat armed; a held inc only repeats after a fresh rise in a set state
    always_comb begin
        pulse_d = 1'b0;
        rcnt_d  = '0;
        rep_d   = 1'b0;
        if (in_set && !mode_rise && inc) begin
            if (inc_rise) begin
                pulse_d = 1'b1;
                rcnt_d  = CW'(1);
            end else if (rcnt != '0) begin
                pulse_d = due;
                rcnt_d  = due ? CW'(1) : rcnt + 1'b1;
                rep_d   = rep | due;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q    <= 1'b1;
            inc_q     <= 1'b1;
            in_set    <= 1'b0;
            idx       <= '0;
            rcnt      <= '0;
            rep       <= 1'b0;
            set_sel   <= '0;
            setting   <= 1'b0;
            inc_pulse <= 1'b0;
        end else begin
            mode_q    <= mode;
            inc_q     <= inc;
            in_set    <= in_set_d;
            idx       <= idx_d;
            rcnt      <= rcnt_d;
            rep       <= rep_d;
            set_sel   <= in_set_d ? N_FIELDS'(1) << idx_d : '0;
            setting   <= in_set_d;
            inc_pulse <= pulse_d;
        end
    end
endmodule

// File: tb/tb_digitalclock_setctrl.sv
// tb_digitalclock_setctrl: directed stimulus with a cycle model of the set controller plus hand-computed checkpoints.
module tb_digitalclock_setctrl;
    localparam int N   = 2;
    localparam int DLY = 8;
    localparam int PER = 4;
    localparam int TO  = 64;

    logic       clk = 0, rst = 1, mode = 0, inc = 0;
    logic [1:0] set_sel;
    logic       setting, inc_pulse;
    logic       s_mode = 0, s_inc = 0, s_rst = 0;
    int         total = 0, bad = 0;

    digitalclock_setctrl #(
        .N_FIELDS(N), .REPEAT_DLY(DLY), .REPEAT_PER(PER), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .inc(inc),
        .set_sel(set_sel), .setting(setting), .inc_pulse(inc_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        s_mode <= mode;
        s_inc  <= inc;
        s_rst  <= rst;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
        end
    endtask

    task automatic cyc(input logic m, input logic i, input int k = 1);
        for (int j = 0; j < k; j++) begin
            mode = m;
            inc  = i;
            @(posedge clk);
            #1;
        end
    endtask

    // Model: state 0 is run, s>0 is setting field s-1; pulses derived from time since the press.
    initial begin : model
        int st, press, last_act, n, d;
        bit pm, pi, mr, ir, pulse;
        st = 0; press = -1; last_act = 0; n = 0; pm = 1; pi = 1; pulse = 0;
        forever begin
            @(negedge clk);
            if (!rst || !s_rst) begin
                st = 0; press = -1; pm = 1; pi = 1; pulse = 0;
            end else begin
                mr = s_mode && !pm;
                ir = s_inc && !pi;
                pulse = 0;
                if (mr) begin
                    st = (st == N) ? 0 : st + 1;
                    press = -1;
                    last_act = n;
                end else if (st != 0) begin
                    if (!s_inc) press = -1;
                    else begin
                        if (ir) press = n;
                        last_act = n;
                    end
                    if (press >= 0) begin
                        d = n - press;
                        pulse = (d == 0) || (d >= DLY && (d - DLY) % PER == 0);
                    end
`ifdef SETCTRL_TIMEOUT_EN
                    if (!s_inc && n - last_act >= TO - 1) st = 0;
`endif
                end else press = -1;
                pm = s_mode;
                pi = s_inc;
                n++;
            end
            chk("m_sel", set_sel, st == 0 ? 0 : 1 << (st - 1));
            chk("m_setting", setting, st != 0);
            chk("m_pulse", inc_pulse, pulse);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int np;
        #1 rst = 0;
        #1 chk("rst_sel", set_sel, 0);
        chk("rst_pulse", inc_pulse, 0);
        cyc(0, 0, 3);
        rst = 1;
        cyc(0, 0, 2);
        chk("idle_sel", set_sel, 2'b00);
        // three single-cycle mode presses
        cyc(1, 0); chk("m1_sel", set_sel, 2'b01); chk("m1_setting", setting, 1);
        cyc(0, 0, 2); chk("m1_hold", set_sel, 2'b01);
        cyc(1, 0); chk("m2_sel", set_sel, 2'b10);
        cyc(0, 0);
        cyc(1, 0); chk("m3_sel", set_sel, 2'b00); chk("m3_setting", setting, 0);
        cyc(0, 0);
        // mode held 20 cycles advances once
        cyc(1, 0); chk("mh_first", set_sel, 2'b01);
        cyc(1, 0, 19); chk("mh_held", set_sel, 2'b01);
        cyc(0, 0);
        // inc held 20 cycles in SET_0
        np = 0;
        for (int j = 0; j < 20; j++) begin
            cyc(0, 1);
            chk("rep_pulse", inc_pulse, (j == 0 || j == 8 || j == 12 || j == 16));
            np += inc_pulse;
        end
        chk("rep_count", np, 4);
        np = 0;
        for (int j = 0; j < 6; j++) begin
            cyc(0, 0);
            np += inc_pulse;
        end
        chk("rep_after", np, 0);
        cyc(1, 0); cyc(0, 0); cyc(1, 0); cyc(0, 0);
        chk("back_run", set_sel, 2'b00);
        // inc ignored in run
        for (int j = 0; j < 5; j++) begin
            cyc(0, 1); chk("run_inc", inc_pulse, 0);
            cyc(0, 0); chk("run_inc_lo", inc_pulse, 0);
        end
        chk("run_sel", set_sel, 2'b00);
        // mode and inc rising together: mode wins, held inc stays quiet
        cyc(1, 0); cyc(0, 0);
        cyc(1, 1); chk("pri_sel", set_sel, 2'b10); chk("pri_pulse", inc_pulse, 0);
        for (int j = 0; j < 10; j++) begin
            cyc(0, 1); chk("pri_held", inc_pulse, 0);
        end
        cyc(0, 0);
        cyc(0, 1); chk("pri_repress", inc_pulse, 1);
        cyc(0, 0);
        cyc(1, 0); cyc(0, 0);
        // mode held high across reset release
        mode = 1; rst = 0;
        #1 chk("rstm_sel", set_sel, 2'b00);
        cyc(1, 0, 3);
        rst = 1;
        cyc(1, 0, 5); chk("rstm_norise", set_sel, 2'b00);
        cyc(0, 0);
        cyc(1, 0); chk("rstm_rise", set_sel, 2'b01);
        cyc(0, 0);
        // reset in the middle of auto-repeat
        cyc(0, 1); chk("mid_p0", inc_pulse, 1);
        cyc(0, 1, 7);
        cyc(0, 1); chk("mid_p8", inc_pulse, 1);
        rst = 0;
        #1 chk("async_pulse", inc_pulse, 0);
        chk("async_sel", set_sel, 2'b00);
        chk("async_setting", setting, 0);
        cyc(0, 1, 2);
        rst = 1;
        np = 0;
        for (int j = 0; j < 12; j++) begin
            cyc(0, 1);
            np += inc_pulse;
        end
        chk("post_rst_pulses", np, 0);
        chk("post_rst_sel", set_sel, 2'b00);
        cyc(0, 0, 2);
`ifdef SETCTRL_TIMEOUT_EN
        cyc(1, 0); cyc(0, 0); cyc(1, 0);
        cyc(0, 0, 62); chk("to_before", set_sel, 2'b10);
        cyc(0, 0); chk("to_expire", set_sel, 2'b00);
        cyc(0, 0);
        cyc(1, 0); cyc(0, 0); cyc(1, 0);
        cyc(0, 0, 39);
        cyc(0, 1);
        cyc(0, 0, 62); chk("to_restart_before", set_sel, 2'b10);
        cyc(0, 0); chk("to_restart_expire", set_sel, 2'b00);
`else
        cyc(1, 0); cyc(0, 0); cyc(1, 0);
        cyc(0, 0, 200); chk("no_timeout", set_sel, 2'b10);
`endif
        cyc(0, 0, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/digitalclock_setctrl.md
DIGITALCLOCK_SETCTRL -- requirements
Module: digitalclock_setctrl

Interface
REQ-001 SHALL have parameter N_FIELDS, default 2, number of settable time fields (index 0 = hours, 1 = minutes, ...), legal range 1..8.
REQ-002 SHALL have parameter REPEAT_DLY, default 8, cycles from first increment pulse to first auto-repeat pulse, legal range >=2.
REQ-003 SHALL have parameter REPEAT_PER, default 4, cycles between auto-repeat pulses, legal range >=1.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 64, idle cycles in a set state before returning to run, legal range >=2.
REQ-005 SHALL have port clk, input, 1, sole clock, all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port mode, input, 1, synchronous debounced mode-button level.
REQ-008 SHALL have port inc, input, 1, synchronous debounced increment-button level.
REQ-009 SHALL have port set_sel, output, N_FIELDS, one-hot field currently being set, all-zero in run.
REQ-010 SHALL have port setting, output, 1, high in any set state (OR of set_sel).
REQ-011 SHALL have port inc_pulse, output, 1, single-cycle increment strobe for the selected field.

Function
REQ-012 SHALL detect mode rising edge as mode=1 in current sample and 0 in previous sample; level-held mode SHALL cause no further advance.
REQ-013 SHALL implement states RUN and SET_k (k = 0..N_FIELDS-1), held as a state bit plus a field-index counter of width max(1,$clog2(N_FIELDS)).
REQ-014 SHALL transition on mode rise: RUN->SET_0; SET_k->SET_k+1 for k<N_FIELDS-1; SET_(N_FIELDS-1)->RUN (N_FIELDS=1: SET_0->RUN).
REQ-015 SHALL drive set_sel, setting and inc_pulse from registers; changes appear in the cycle after the clock edge that samples the causing input edge.
REQ-016 SHALL, in SET_k, assert inc_pulse for exactly one cycle in the cycle after the edge sampling an inc rising edge (first pulse, cycle t).
REQ-017 SHALL, while inc stays high in SET_k, assert inc_pulse again at t+REPEAT_DLY and every REPEAT_PER cycles thereafter; inc falling stops repeat immediately, no pulse.
REQ-018 SHALL ignore inc in RUN: no inc_pulse, repeat counter held at 0.
REQ-019 SHALL, on a mode rise sampled in the same cycle as an inc rise or a due repeat pulse, give mode priority: advance state, suppress the pulse, clear repeat counter; inc still held after the advance SHALL NOT pulse until released and pressed again.
REQ-020 SHALL use a saturating repeat counter (width $clog2(REPEAT_DLY+1)); no wrap-around pulses.

Reset
REQ-021 SHALL, while rst=0, force RUN, set_sel=0, setting=0, inc_pulse=0, all counters 0, independent of clk.
REQ-022 SHALL reset both edge-detect history registers to 1, so a button held through reset release produces no edge until released and re-pressed.
REQ-023 SHALL, on reset asserted mid-repeat or mid-set, abandon the operation with no trailing pulse after release.

Configuration
REQ-024 SHALL, when SETCTRL_TIMEOUT_EN is defined, count idle cycles in any SET_k (inc=0 and no mode rise); count cleared on SET entry, mode rise, or inc=1.
REQ-025 SHALL, with SETCTRL_TIMEOUT_EN defined, return to RUN so that set_sel=0 is visible exactly TIMEOUT_CYC cycles after the last active cycle; a mode rise in the expiry cycle takes priority.
REQ-026 SHALL, without SETCTRL_TIMEOUT_EN, contain no timeout counter and remain in SET_k indefinitely until a mode rise.

Verification
REQ-027 SHALL cover: defaults, three single-cycle mode pulses from reset -> set_sel 01, 10, 00 each one cycle after the sampled edge; mode held 20 cycles -> only one advance.
REQ-028 SHALL cover: SET_0, inc held 20 cycles -> inc_pulse at t, t+8, t+12, t+16 (4 pulses), none after release.
REQ-029 SHALL cover: RUN, inc pulsed 5 times -> inc_pulse never asserted, set_sel stays 00.
REQ-030 SHALL cover: mode and inc rising in same cycle in SET_0 -> set_sel=10, no inc_pulse; inc stays high 10 cycles -> no pulse.
REQ-031 SHALL cover: mode held high across rst release -> state RUN until mode drops and rises again; rst asserted mid-repeat -> outputs 0 asynchronously.
REQ-032 SHALL cover: SETCTRL_TIMEOUT_EN defined, enter SET_1, idle -> set_sel=00 exactly 64 cycles later; inc pulse at cycle 40 restarts the count; undefined -> set_sel stays 10 after 200 cycles.
